// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared definitions for the APB memory arbiter slice.
//   apb_arb_st_e : transfer FSM states (IDLE, SETUP, ACCESS)
//   APB_AW       : default address width
//   APB_DW       : default data width
// ---------------------------------------------------------------------------
package apb_arb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_st_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The winner is the first set bit of
// req found by searching upward from ptr and wrapping at NREQ.
// Ports:
//   req        in   NREQ  request vector
//   ptr        in   IW    index where the search starts
//   gnt_onehot out  NREQ  one-hot winner (all zero when no request)
//   gnt_idx    out  IW    binary winner index (zero when no request)
//   any        out  1     at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    // Walk the NREQ candidates in priority order starting at ptr; the first
    // active one wins and later candidates are ignored via the any flag.
    always_comb begin
        int cand;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand       = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any              = 1'b1;
                gnt_idx          = IW'(cand);
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// apb_mem_arbiter
// Round-robin APB master sharing one APB memory slave between NREQ local
// requesters. One SETUP/ACCESS transfer per granted command, followed by a
// one-cycle response pulse to the winner. ACCESS phases stalled for TIMEOUT
// cycles are aborted with rsp_err (TIMEOUT = 0 disables the abort).
// Ports:
//   pclk, presetn          clock, async active-low reset
//   req_valid/req_write    per-requester command valid / write flag
//   req_addr/req_wdata     packed per-requester address / write data
//   req_ready              one-hot command accept (IDLE only)
//   rsp_valid              one-hot completion pulse
//   rsp_rdata/rsp_err      response data / timeout flag, held until next rsp
//   psel/penable/pwrite    APB control
//   paddr/pwdata/prdata    APB address / write data / read data
//   pready                 APB ready
// ---------------------------------------------------------------------------
module apb_mem_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [DW-1:0]     pwdata,
    input  logic [DW-1:0]     prdata,
    input  logic              pready
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_arb_st_e     state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (arb_gnt),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    // Next-state and output decode. The winner's command is captured when
    // leaving IDLE so the APB signals stay frozen for the whole transfer.
    // Completion and abort share the same exit path; they differ only in
    // the response data and error flag.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;
        psel        = 1'b0;
        penable     = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    // Gate with presetn so no accept is seen while in reset.
                    req_ready = arb_gnt & {NREQ{presetn}};
                    gidx_d    = arb_idx;
                    pwrite_d  = req_write[arb_idx];
                    paddr_d   = req_addr[arb_idx*AW +: AW];
                    pwdata_d  = req_wdata[arb_idx*DW +: DW];
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                psel    = 1'b1;
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || (TIMEOUT != 0 && int'(cnt_q) == TIMEOUT - 1)) begin
                    state_d             = IDLE;
                    rsp_valid_d[gidx_q] = 1'b1;
                    rsp_err_d           = !pready;
                    rsp_rdata_d         = (pready && !pwrite_q) ? prdata : '0;
                    ptr_d               = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset returns everything to
    // zero so an in-flight command is dropped without a response.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            cnt_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            cnt_q       <= cnt_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_arbiter
// Directed bench for apb_mem_arbiter with NREQ=4 and TIMEOUT=4, driving a
// small APB memory model preloaded with mem[i]=i.
// ---------------------------------------------------------------------------
module tb_apb_mem_arbiter;
    import apb_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int AW      = APB_AW;
    localparam int DW      = APB_DW;
    localparam int TIMEOUT = 4;

    logic               pclk = 1'b0;
    logic               presetn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic [DW-1:0]      prdata;
    logic               pready;

    logic               forcePreadyLow;
    logic               memLoad;
    logic [DW-1:0]      mem [0:63];

    int assertCount = 0;
    int failCount   = 0;

    apb_mem_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    // Free-running APB clock.
    always #5 pclk = ~pclk;

    // Memory slave: zero-wait unless stalled, combinational read data,
    // writes land on the edge that completes the ACCESS phase.
    assign pready = ~forcePreadyLow;
    assign prdata = mem[paddr[5:0]];

    always @(posedge pclk) begin
        if (memLoad) begin
            for (int i = 0; i < 64; i++) mem[i] <= DW'(i);
        end else if (psel && penable && pready && pwrite) begin
            mem[paddr[5:0]] <= pwdata;
        end
    end

    // Advance to just after the next rising edge.
    task automatic waitCycle();
        @(posedge pclk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a command on requester idx.
    task automatic applyStimulus(input int idx, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        req_valid[idx]            = 1'b1;
        req_write[idx]            = wr;
        req_addr[idx*AW +: AW]    = addr;
        req_wdata[idx*DW +: DW]   = wdata;
    endtask

    // One complete transfer with pready high, checked cycle by cycle.
    task automatic doTransfer(input int idx, input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] expRdata);
        applyStimulus(idx, wr, addr, wdata);
        #1;
        checkOutput("grant_ready", req_ready, 64'(1) << idx);
        waitCycle();
        req_valid[idx] = 1'b0;
        #1;
        checkOutput("setup_ctrl", {psel, penable}, 2'b10);
        checkOutput("setup_no_ready", req_ready, 0);
        checkOutput("setup_addr", paddr, addr);
        checkOutput("setup_write", pwrite, wr);
        if (wr) checkOutput("setup_wdata", pwdata, wdata);
        waitCycle();
        #1;
        checkOutput("access_ctrl", {psel, penable}, 2'b11);
        checkOutput("access_addr", paddr, addr);
        waitCycle();
        #1;
        checkOutput("rsp_valid", rsp_valid, 64'(1) << idx);
        checkOutput("rsp_rdata", rsp_rdata, expRdata);
        checkOutput("rsp_err", rsp_err, 0);
        checkOutput("rsp_psel_low", psel, 0);
    endtask

    // Requesters in mask all read fixed addresses 40+i continuously; the
    // grant order must follow seq and each response lands 3 cycles later.
    task automatic runArbitration(input logic [NREQ-1:0] mask, input int n, input int seq[8]);
        for (int i = 0; i < NREQ; i++) begin
            req_write[i]          = 1'b0;
            req_addr[i*AW +: AW]  = AW'(40 + i);
        end
        req_valid = mask;
        for (int t = 0; t < n; t++) begin
            #1;
            checkOutput("rr_grant", req_ready, 64'(1) << seq[t]);
            if (t > 0) begin
                checkOutput("rr_rsp_valid", rsp_valid, 64'(1) << seq[t-1]);
                checkOutput("rr_rsp_rdata", rsp_rdata, 40 + seq[t-1]);
            end
            waitCycle();
            if (t == n - 1) req_valid = '0;
            #1;
            checkOutput("rr_setup_addr", paddr, 40 + seq[t]);
            waitCycle();
            waitCycle();
        end
        #1;
        checkOutput("rr_last_rsp_valid", rsp_valid, 64'(1) << seq[n-1]);
        checkOutput("rr_last_rsp_rdata", rsp_rdata, 40 + seq[n-1]);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        req_valid      = '0;
        req_write      = '0;
        req_addr       = '0;
        req_wdata      = '0;
        forcePreadyLow = 1'b0;
        memLoad        = 1'b1;
        presetn        = 1'b0;
        repeat (3) @(posedge pclk);
        #2;

        $display("[TB] reset state");
        req_valid = 4'b0001;
        #1;
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_ctrl", {psel, penable, pwrite}, 3'b000);
        checkOutput("reset_paddr", paddr, 0);
        checkOutput("reset_pwdata", pwdata, 0);
        checkOutput("reset_rsp", {rsp_valid, rsp_err}, 0);
        checkOutput("reset_rdata", rsp_rdata, 0);
        req_valid = '0;
        memLoad   = 1'b0;
        presetn   = 1'b1;
        waitCycle();

        $display("[TB] requester 0 reads address 5");
        doTransfer(0, 1'b0, 5, 0, 5);
        waitCycle();
        #1;
        checkOutput("rsp_single_pulse", rsp_valid, 0);
        checkOutput("rdata_hold", rsp_rdata, 5);

        $display("[TB] requester 1 write then read address 10");
        doTransfer(1, 1'b1, 10, 32'hDEAD_BEEF, 0);
        doTransfer(1, 1'b0, 10, 0, 32'hDEAD_BEEF);

        $display("[TB] requesters 0 and 1 contending");
        runArbitration(4'b0011, 8, '{0, 1, 0, 1, 0, 1, 0, 1});

        $display("[TB] timeout abort");
        forcePreadyLow = 1'b1;
        applyStimulus(0, 1'b0, 7, 0);
        #1;
        checkOutput("to_grant", req_ready, 4'b0001);
        waitCycle();
        req_valid[0] = 1'b0;
        #1;
        checkOutput("to_setup", {psel, penable}, 2'b10);
        for (int k = 0; k < TIMEOUT; k++) begin
            waitCycle();
            #1;
            checkOutput("to_access", {psel, penable}, 2'b11);
            checkOutput("to_no_rsp", rsp_valid, 0);
        end
        waitCycle();
        #1;
        checkOutput("to_rsp_valid", rsp_valid, 4'b0001);
        checkOutput("to_rsp_err", rsp_err, 1);
        checkOutput("to_rsp_rdata", rsp_rdata, 0);
        checkOutput("to_idle", psel, 0);
        forcePreadyLow = 1'b0;
        doTransfer(1, 1'b0, 12, 0, 12);

        $display("[TB] reset during ACCESS");
        forcePreadyLow = 1'b1;
        applyStimulus(0, 1'b0, 3, 0);
        #1;
        checkOutput("rst_grant", req_ready, 4'b0001);
        waitCycle();
        req_valid[0] = 1'b0;
        applyStimulus(1, 1'b0, 13, 0);
        applyStimulus(2, 1'b0, 14, 0);
        waitCycle();
        #1;
        checkOutput("rst_access", {psel, penable}, 2'b11);
        checkOutput("rst_busy_no_ready", req_ready, 0);
        #1;
        presetn = 1'b0;
        #1;
        checkOutput("rst_ctrl_zero", {psel, penable, pwrite}, 3'b000);
        checkOutput("rst_paddr_zero", paddr, 0);
        checkOutput("rst_rdata_zero", rsp_rdata, 0);
        checkOutput("rst_rsp_zero", {rsp_valid, rsp_err}, 0);
        checkOutput("rst_ready_zero", req_ready, 0);
        waitCycle();
        waitCycle();
        #1;
        checkOutput("rst_no_rsp", rsp_valid, 0);
        forcePreadyLow = 1'b0;
        presetn        = 1'b1;
        #1;
        checkOutput("rst_ptr_zero_grant", req_ready, 4'b0010);
        doTransfer(1, 1'b0, 13, 0, 13);
        doTransfer(2, 1'b0, 14, 0, 14);

        $display("[TB] requesters 3 and 1 from ptr 0");
        presetn = 1'b0;
        waitCycle();
        presetn = 1'b1;
        waitCycle();
        runArbitration(4'b1010, 3, '{1, 3, 1, 0, 0, 0, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
